// File: rtl/pb_pkg.sv
// Shared types for the push-button event path: event type and the
// arbiter FSM state encoding.
package pb_pkg;

  typedef enum logic {
    EV_PRESS   = 1'b0,
    EV_RELEASE = 1'b1
  } ev_type_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

endpackage : pb_pkg

// File: rtl/pb_event_arbiter_rr_pick.sv
// Combinational round-robin picker. The request vector is doubled and
// rotated so that the search starts just after last_grant; a priority
// encoder then finds the first request and the index is mapped back.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_valid
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [ID_W:0]  start;
  logic [ID_W:0]  idx;

  // Rotate requests to start after last_grant, then pick the lowest set bit.
  always_comb begin
    dbl         = {req, req};
    start       = (last_grant >= ID_W'(N - 1)) ? '0 : ({1'b0, last_grant} + 1'b1);
    rot         = dbl[start +: N];
    grant_valid = |req;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = start + (ID_W + 1)'(k);
        if (idx >= (ID_W + 1)'(N)) begin
          idx = idx - (ID_W + 1)'(N);
        end
      end
    end
    grant_id = idx[ID_W-1:0];
  end

endmodule : rr_pick

// File: rtl/pb_event_arbiter.sv
// Serialises per-channel press/release pulses into one ordered event
// stream. Each channel latches at most one pending press and one pending
// release; channels are served round-robin, press before release.
//
// Handshake: ev_valid is asserted in ARB_OFFER and holds ev_id/ev_type
// stable until a cycle with ev_valid && ev_ready; only that edge transfers
// the event. ev_ready while ev_valid=0 has no effect.
module pb_event_arbiter
  import pb_pkg::*;
#(
  parameter int N_PB = 4,
  parameter int ID_W = $clog2(N_PB)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_PB-1:0] pressed_pulse,
  input  logic [N_PB-1:0] released_pulse,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [ID_W-1:0] ev_id,
  output logic            ev_type,
  output logic            pending_any,
  output logic [N_PB-1:0] overflow,
  input  logic            clr_overflow,
  output logic            dbg_state
);

  arb_state_t      state_q, state_d;
  logic [N_PB-1:0] press_pend_q, press_pend_d;
  logic [N_PB-1:0] rel_pend_q, rel_pend_d;
  logic [N_PB-1:0] overflow_q, overflow_d;
  logic [ID_W-1:0] ev_id_q, ev_id_d;
  ev_type_t        ev_type_q, ev_type_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic            pending_q, pending_d;

  logic            handshake;
  logic [N_PB-1:0] cons_press, cons_rel;
  logic [ID_W-1:0] grant_id;
  logic            grant_valid;

  rr_pick #(
    .N(N_PB)
  ) u_pick (
    .req        (press_pend_q | rel_pend_q),
    .last_grant (last_grant_q),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  // Decode which single pending flag the current handshake consumes.
  always_comb begin
    handshake  = (state_q == ARB_OFFER) && ev_ready;
    cons_press = '0;
    cons_rel   = '0;
    if (handshake) begin
      if (ev_type_q == EV_PRESS) begin
        cons_press[ev_id_q] = 1'b1;
      end else begin
        cons_rel[ev_id_q] = 1'b1;
      end
    end
  end

  // Pending flags and sticky overflow. A pulse on a flag that is being
  // consumed this cycle simply re-arms it; a pulse on a flag that stays
  // set is lost and recorded. A new loss beats a same-cycle clear.
  always_comb begin
    press_pend_d = (press_pend_q & ~cons_press) | pressed_pulse;
    rel_pend_d   = (rel_pend_q & ~cons_rel) | released_pulse;
    overflow_d   = (clr_overflow ? '0 : overflow_q)
                 | (pressed_pulse & press_pend_q & ~cons_press)
                 | (released_pulse & rel_pend_q & ~cons_rel);
    pending_d    = |(press_pend_d | rel_pend_d);
  end

  // Arbiter FSM: pick a channel when idle, hold the offer until accepted.
  always_comb begin
    state_d      = state_q;
    ev_id_d      = ev_id_q;
    ev_type_d    = ev_type_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d   = ARB_OFFER;
          ev_id_d   = grant_id;
          ev_type_d = press_pend_q[grant_id] ? EV_PRESS : EV_RELEASE;
        end
      end
      ARB_OFFER: begin
        if (ev_ready) begin
          state_d      = ARB_IDLE;
          last_grant_d = ev_id_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight offer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      press_pend_q <= '0;
      rel_pend_q   <= '0;
      overflow_q   <= '0;
      ev_id_q      <= '0;
      ev_type_q    <= EV_PRESS;
      last_grant_q <= ID_W'(N_PB - 1);
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
      overflow_q   <= overflow_d;
      ev_id_q      <= ev_id_d;
      ev_type_q    <= ev_type_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
    end
  end

  assign ev_valid    = (state_q == ARB_OFFER);
  assign ev_id       = ev_id_q;
  assign ev_type     = ev_type_q;
  assign pending_any = pending_q;
  assign overflow    = overflow_q;
  assign dbg_state   = (state_q == ARB_OFFER);

endmodule : pb_event_arbiter

// File: tb/tb_pb_event_arbiter.sv
// Bench for pb_event_arbiter: directed scenarios plus a randomized phase,
// checked against a transaction-level reference model and a scoreboard.
module tb_pb_event_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int W    = ID_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    pressed_pulse, released_pulse;
  logic            ev_valid, ev_ready, ev_type, pending_any, clr_overflow, dbg_state;
  logic [ID_W-1:0] ev_id;
  logic [N-1:0]    overflow;

  pb_event_arbiter #(.N_PB(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .pressed_pulse (pressed_pulse),
    .released_pulse(released_pulse),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_id         (ev_id),
    .ev_type       (ev_type),
    .pending_any   (pending_any),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow),
    .dbg_state     (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else if (n_checks - n_pass <= 40)
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  function automatic int got_id(input int k);
    logic [W-1:0] e;
    e = (k < got_q.size()) ? got_q[k] : '1;
    return int'(e[W-1:1]);
  endfunction

  function automatic int got_type(input int k);
    logic [W-1:0] e;
    e = (k < got_q.size()) ? got_q[k] : '1;
    return int'(e[0]);
  endfunction

  // ---------------- reference model ----------------
  // Event-level view: one pending press/release bit per channel, one offer
  // slot, and a rotating search start after the last served channel.
  logic [N-1:0] m_press, m_rel, m_ovf, nxt_press, nxt_rel, set_ovf;
  int           m_last, m_id, j;
  bit           m_offer, m_type, m_pend, hs, found, cp, cr, np, nr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_press = '0; m_rel = '0; m_ovf = '0;
      m_last  = N - 1; m_offer = 1'b0; m_id = 0; m_type = 1'b0; m_pend = 1'b0;
      exp_q.delete();
    end else begin
      hs      = m_offer && ev_ready;
      set_ovf = '0;
      for (int i = 0; i < N; i++) begin
        cp = hs && (m_id == i) && !m_type;
        cr = hs && (m_id == i) && m_type;
        np = m_press[i] && !cp;
        nr = m_rel[i] && !cr;
        if (pressed_pulse[i])  begin if (np) set_ovf[i] = 1'b1; np = 1'b1; end
        if (released_pulse[i]) begin if (nr) set_ovf[i] = 1'b1; nr = 1'b1; end
        nxt_press[i] = np;
        nxt_rel[i]   = nr;
      end
      if (hs) begin
        m_last  = m_id;
        m_offer = 1'b0;
      end else if (!m_offer) begin
        found = 1'b0;
        for (int s = 1; s <= N; s++) begin
          j = (m_last + s) % N;
          if (!found && (m_press[j] || m_rel[j])) begin
            found  = 1'b1;
            m_id   = j;
            m_type = !m_press[j];
          end
        end
        if (found) begin
          m_offer = 1'b1;
          exp_q.push_back({m_id[ID_W-1:0], m_type});
        end
      end
      m_press = nxt_press;
      m_rel   = nxt_rel;
      m_ovf   = (clr_overflow ? '0 : m_ovf) | set_ovf;
      m_pend  = |(m_press | m_rel);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("ev_valid", int'(ev_valid), int'(m_offer));
      check("pending_any", int'(pending_any), int'(m_pend));
      check("overflow", int'(overflow), int'(m_ovf));
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got id %0d type %0d, expected none", ev_id, ev_type);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("ev_id", int'(ev_id), int'(e[W-1:1]));
          check("ev_type", int'(ev_type), int'(e[0]));
        end
        got_q.push_back({ev_id, ev_type});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic [N-1:0] p, input logic [N-1:0] r);
    pressed_pulse  = p;
    released_pulse = r;
    step();
    pressed_pulse  = '0;
    released_pulse = '0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((ev_valid || pending_any) && k < budget) begin
      step();
      k++;
    end
    check("drain_busy", int'(ev_valid || pending_any), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; pressed_pulse = '0; released_pulse = '0;
    ev_ready = 1'b0; clr_overflow = 1'b0;
    cycles(3);
    check("rst_valid", int'(ev_valid), 0);
    check("rst_id", int'(ev_id), 0);
    check("rst_type", int'(ev_type), 0);
    check("rst_pending", int'(pending_any), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_state", int'(dbg_state), 0);
    #1 rst = 1'b1;
    cycles(2);

    // Round-robin from reset: 0,1,3
    ev_ready = 1'b1;
    got_q.delete();
    pulse(4'b1011, 4'b0000);
    wait_idle(40);
    check("rr1_count", got_q.size(), 3);
    check("rr1_0", got_id(0), 0);
    check("rr1_1", got_id(1), 1);
    check("rr1_2", got_id(2), 3);

    // Single press, latency 2, single-cycle valid
    pulse(4'b0100, 4'b0000);
    check("sp_valid_early", int'(ev_valid), 0);
    step();
    check("sp_valid", int'(ev_valid), 1);
    check("sp_id", int'(ev_id), 2);
    check("sp_type", int'(ev_type), 0);
    step();
    check("sp_valid_drop", int'(ev_valid), 0);
    check("sp_pending", int'(pending_any), 0);

    // Round-robin with last_grant=1: 3,0,1
    pulse(4'b0010, 4'b0000);
    wait_idle(20);
    got_q.delete();
    pulse(4'b1011, 4'b0000);
    wait_idle(40);
    check("rr2_count", got_q.size(), 3);
    check("rr2_0", got_id(0), 3);
    check("rr2_1", got_id(1), 0);
    check("rr2_2", got_id(2), 1);

    // Stall: offer holds for 20 cycles
    ev_ready = 1'b0;
    got_q.delete();
    pulse(4'b0010, 4'b0000);
    step();
    for (int i = 0; i < 20; i++) begin
      check("stall_valid", int'(ev_valid), 1);
      check("stall_id", int'(ev_id), 1);
      check("stall_type", int'(ev_type), 0);
      step();
    end
    ev_ready = 1'b1;
    step();
    check("stall_after", int'(ev_valid), 0);
    check("stall_count", got_q.size(), 1);

    // Overflow: second press on channel 0 while the first is unserved
    ev_ready = 1'b0;
    got_q.delete();
    pulse(4'b0001, 4'b0000);
    cycles(4);
    pulse(4'b0001, 4'b0000);
    check("ovf_set", int'(overflow), 1);
    ev_ready = 1'b1;
    wait_idle(40);
    check("ovf_count", got_q.size(), 1);
    check("ovf_ev_id", got_id(0), 0);
    check("ovf_ev_type", got_type(0), 0);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("ovf_clear", int'(overflow), 0);

    // Same channel press+release, press re-armed on its consume cycle
    ev_ready = 1'b0;
    got_q.delete();
    pulse(4'b0100, 4'b0100);
    step();
    check("sc_valid", int'(ev_valid), 1);
    check("sc_type", int'(ev_type), 0);
    ev_ready = 1'b1;
    pulse(4'b0100, 4'b0000);
    check("sc_no_ovf", int'(overflow), 0);
    wait_idle(40);
    check("sc_count", got_q.size(), 3);
    check("sc_e0", got_id(0) * 2 + got_type(0), 4);
    check("sc_e1", got_id(1) * 2 + got_type(1), 4);
    check("sc_e2", got_id(2) * 2 + got_type(2), 5);
    check("sc_no_ovf_end", int'(overflow), 0);

    // Async reset mid-offer
    ev_ready = 1'b0;
    pulse(4'b1000, 4'b0000);
    step();
    pulse(4'b0010, 4'b0000);
    check("ar_valid_before", int'(ev_valid), 1);
    #1 rst = 1'b0;
    #1;
    check("ar_valid", int'(ev_valid), 0);
    check("ar_pending", int'(pending_any), 0);
    check("ar_state", int'(dbg_state), 0);
    cycles(2);
    #1 rst = 1'b1;
    step();
    ev_ready = 1'b1;
    got_q.delete();
    pulse(4'b0110, 4'b0000);
    wait_idle(40);
    check("ar_count", got_q.size(), 2);
    check("ar_first", got_id(0), 1);
    check("ar_second", got_id(1), 2);

    // Randomized phase
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        pressed_pulse[b]  = ($urandom_range(0, 6) == 0);
        released_pulse[b] = ($urandom_range(0, 6) == 0);
      end
      ev_ready     = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      step();
    end
    pressed_pulse  = '0;
    released_pulse = '0;
    clr_overflow   = 1'b0;
    ev_ready       = 1'b1;
    wait_idle(100);
    step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pb_event_arbiter
